// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core.
// Redirect kinds, PC-stage FSM states and word size.
package mips_pkg;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'b00,
        REDIR_BR   = 2'b01,
        REDIR_J    = 2'b10,
        REDIR_JR   = 2'b11
    } redir_t;

    typedef enum logic [1:0] {
        S_HOLD = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/pc_sequencer_strobe_edge.sv
// Rising-edge detector for a level strobe from the stage controller.
// The edge is visible in the same cycle the strobe first reads high.
module strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= d;
    end

    assign rise = d & ~q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: PC+4 stepping, EXE redirects,
// retired-instruction counting and self-loop halt detection.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_clk,
    input  logic              reset_clk,
    input  logic              done_tick,
    input  logic [1:0]        redir_kind,
    input  logic [25:0]       redir_imm,
    input  logic [ADDR_W-1:0] redir_reg,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              pc_update,
    output logic [CNT_W-1:0]  instr_count,
    output logic              halted,
    output logic              align_err
);

    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] J_MASK = ADDR_W'(28'hFFF_FFFF);

    state_t            state, state_n;
    redir_t            kind;
    logic              inc_ev, ret_ev;
    logic [ADDR_W-1:0] base, target, br_off, pc_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              upd_n, aerr_n;

    strobe_edge u_inc (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (pc_clk),
        .rise (inc_ev)
    );

    strobe_edge u_ret (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (done_tick),
        .rise (ret_ev)
    );

    assign kind     = redir_t'(redir_kind);
    assign pc_plus4 = pc + STEP;
    assign halted   = (state == S_HALT);

    // A concurrent increment makes pc+4 the base for both target and halt compare.
    always_comb begin
        base   = inc_ev ? pc_plus4 : pc;
        br_off = {{(ADDR_W-18){redir_imm[15]}}, redir_imm[15:0], 2'b00};
        case (kind)
            REDIR_BR: target = base + br_off;
            REDIR_J:  target = (base & ~J_MASK) | ADDR_W'({redir_imm, 2'b00});
            REDIR_JR: target = {redir_reg[ADDR_W-1:2], 2'b00};
            default:  target = base;
        endcase
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = instr_count;
        upd_n   = 1'b0;
        aerr_n  = align_err;
        if (reset_clk) begin
            state_n = S_HOLD;
            pc_n    = RESET_VECTOR;
            cnt_n   = '0;
        end else begin
            case (state)
                S_HOLD: begin
                    state_n = S_RUN;
                    pc_n    = RESET_VECTOR;
                end
                S_RUN: begin
                    if (ret_ev) cnt_n = instr_count + CNT_W'(1);
                    if (kind != REDIR_NONE) begin
                        pc_n  = target;
                        upd_n = 1'b1;
                        if (target == base - STEP) state_n = S_HALT;
                        if (kind == REDIR_JR && redir_reg[1:0] != 2'b00)
                            aerr_n = 1'b1;
                    end else if (inc_ev) begin
                        pc_n  = pc_plus4;
                        upd_n = 1'b1;
                    end
                end
                S_HALT: state_n = S_HALT;
                default: state_n = S_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_HOLD;
            pc          <= RESET_VECTOR;
            instr_count <= '0;
            pc_update   <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_count <= cnt_n;
            pc_update   <= upd_n;
            align_err   <= aerr_n;
        end
    end

endmodule
